// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one byte-level UART transmitter among N_REQ = 2**ID_W
//                byte-stream requesters. Round-robin arbitration is done at
//                packet granularity. A grant is held until the owner marks a
//                byte as last, or until MAX_BURST bytes have been sent.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   system clock, all logic on rising edge
//    reset         in   asynchronous active-high reset
//    req           in   [N_REQ]       per-requester byte valid
//    req_last      in   [N_REQ]       per-requester: current byte ends packet
//    req_data      in   [N_REQ*DBIT]  requester i at [i*DBIT +: DBIT]
//    ack           out  [N_REQ]       one-cycle pulse: byte of requester i taken
//    tx_start      out  one-cycle pulse: transmitter loads tx_din and sends
//    tx_din        out  [DBIT]        byte to transmitter, held until next start
//    tx_done_tick  in   one-cycle pulse: frame including stop bit finished
//    grant_valid   out  a requester currently owns the transmitter
//    grant_id      out  [ID_W]        owner index, valid with grant_valid
//    busy          out  arbiter not idle
// ============================================================================
module uart_tx_arbiter #(
    parameter int ID_W      = 2,
    parameter int DBIT      = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2**ID_W-1:0]       req,
    input  logic [2**ID_W-1:0]       req_last,
    input  logic [2**ID_W*DBIT-1:0]  req_data,
    output logic [2**ID_W-1:0]       ack,
    output logic                     tx_start,
    output logic [DBIT-1:0]          tx_din,
    input  logic                     tx_done_tick,
    output logic                     grant_valid,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    localparam int N_REQ = 2**ID_W;

    localparam logic [N_REQ-1:0] c_one_hot0   = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [7:0]       c_max_burst  = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_rr_ptr;      // most recently released requester
    logic [7:0]      r_burst_cnt;   // bytes sent in the current grant
    logic            r_last_flag;   // byte in flight closes the packet

    logic [ID_W-1:0] w_pick_id;
    logic            w_pick_found;
    logic [ID_W-1:0] w_cand;

    // Round-robin search starting just after r_rr_ptr. Scanning offsets from
    // the farthest to the nearest lets the nearest set bit win. Offset N_REQ
    // truncates to r_rr_ptr itself, i.e. the last releaser has lowest priority.
    always_comb begin
        w_pick_id    = '0;
        w_pick_found = 1'b0;
        w_cand       = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_cand = r_rr_ptr + ID_W'(i);
            if (req[w_cand]) begin
                w_pick_id    = w_cand;
                w_pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= ID_W'(N_REQ - 1);
            r_burst_cnt <= '0;
            r_last_flag <= 1'b0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_din      <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
        end else begin
            // Pulses default low; they can only rise in LOAD, which never
            // repeats on consecutive cycles.
            ack      <= '0;
            tx_start <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        grant_id    <= w_pick_id;
                        grant_valid <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (req[grant_id]) begin
                        tx_din      <= req_data[grant_id*DBIT +: DBIT];
                        tx_start    <= 1'b1;
                        ack         <= c_one_hot0 << grant_id;
                        r_last_flag <= req_last[grant_id];
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                        r_state     <= ST_WAIT;
                    end else begin
                        // Owner withdrew its request: give the line back.
                        r_rr_ptr    <= grant_id;
                        r_burst_cnt <= '0;
                        grant_valid <= 1'b0;
                        busy        <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                ST_WAIT: begin
                    if (tx_done_tick) begin
                        if (r_last_flag || (r_burst_cnt == c_max_burst)) begin
                            r_rr_ptr    <= grant_id;
                            r_burst_cnt <= '0;
                            grant_valid <= 1'b0;
                            busy        <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_state     <= ST_LOAD;
                        end
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    grant_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter. Byte queues
//                per requester, a simple transmitter model returning
//                tx_done_tick 20 cycles after tx_start, and a monitor logging
//                every transfer and grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int ID_W      = 2;
    localparam int N_REQ     = 4;
    localparam int DBIT      = 8;
    localparam int MAX_BURST = 8;
    localparam int DONE_DLY  = 20;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ*DBIT-1:0]   req_data;
    logic [N_REQ-1:0]        ack;
    logic                    tx_start;
    logic [DBIT-1:0]         tx_din;
    logic                    tx_done_tick;
    logic                    grant_valid;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;

    // Request sources: queue-driven requesters plus manual overrides.
    logic [N_REQ-1:0]        auto_req  = '0;
    logic [N_REQ-1:0]        auto_last = '0;
    logic [N_REQ*DBIT-1:0]   auto_data = '0;
    logic [N_REQ-1:0]        man_req   = '0;
    logic [N_REQ-1:0]        man_last  = '0;
    logic [N_REQ*DBIT-1:0]   man_data  = '0;
    logic                    man_tick  = 1'b0;
    logic                    model_tick = 1'b0;
    bit                      tx_model_en = 1'b1;

    assign req          = auto_req  | man_req;
    assign req_last     = auto_last | man_last;
    assign req_data     = auto_data | man_data;
    assign tx_done_tick = model_tick | man_tick;

    uart_tx_arbiter #(
        .ID_W      (ID_W),
        .DBIT      (DBIT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_last     (req_last),
        .req_data     (req_data),
        .ack          (ack),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- requester byte queues ----------------
    logic [8:0] qmem [N_REQ][32];
    int         qhead [N_REQ];
    int         qtail [N_REQ];

    initial begin
        for (int i = 0; i < N_REQ; i++) begin
            qhead[i] = 0;
            qtail[i] = 0;
        end
    end

    task automatic push(input int r, input logic [7:0] d, input logic l);
        qmem[r][qtail[r]] = {l, d};
        qtail[r]++;
    endtask

    function automatic bit queues_empty();
        bit e = 1'b1;
        for (int i = 0; i < N_REQ; i++)
            if (qhead[i] < qtail[i]) e = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (ack[i] && (qhead[i] < qtail[i])) qhead[i]++;
            if (!reset && (qhead[i] < qtail[i])) begin
                auto_req[i]               = 1'b1;
                auto_last[i]              = qmem[i][qhead[i]][8];
                auto_data[i*DBIT +: DBIT] = qmem[i][qhead[i]][7:0];
            end else begin
                auto_req[i]               = 1'b0;
                auto_last[i]              = 1'b0;
                auto_data[i*DBIT +: DBIT] = '0;
            end
        end
    end

    // ---------------- transmitter model ----------------
    int mcnt = 0;
    always @(negedge clk) begin
        model_tick = 1'b0;
        if (reset || !tx_model_en) begin
            mcnt = 0;
        end else if (tx_start) begin
            mcnt = DONE_DLY;
        end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) model_tick = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    int               cyc = 0;
    logic             prev_start = 1'b0;
    logic             prev_ack   = 1'b0;
    logic             prev_gv    = 1'b0;
    int               viol = 0;
    logic [7:0]       tx_log    [$];
    logic [N_REQ-1:0] ack_log   [$];
    logic [ID_W-1:0]  own_log   [$];
    logic [ID_W-1:0]  grant_log [$];
    int               start_cyc [$];
    int               tick_cyc  [$];

    always @(negedge clk) begin
        cyc++;
        if (tx_start) begin
            tx_log.push_back(tx_din);
            ack_log.push_back(ack);
            own_log.push_back(grant_id);
            start_cyc.push_back(cyc);
        end
        if (grant_valid && !prev_gv) grant_log.push_back(grant_id);
        if ((tx_start && prev_start) || ((|ack) && prev_ack)) viol++;
        prev_start = tx_start;
        prev_ack   = |ack;
        prev_gv    = grant_valid;
    end

    always @(posedge clk) begin
        if (tx_done_tick) tick_cyc.push_back(cyc);
    end

    task automatic clear_logs();
        tx_log.delete();
        ack_log.delete();
        own_log.delete();
        grant_log.delete();
        start_cyc.delete();
        tick_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N_REQ; i++) qhead[i] = qtail[i];
        man_req  = '0;
        man_last = '0;
        man_data = '0;
        man_tick = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = !busy && queues_empty() && (man_req == '0);
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_starts(input string tag, input int cnt, input int budget);
        int n = 0;
        while (tx_log.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(tx_log.size() >= cnt), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        // ---------- reset state ----------
        repeat (2) @(negedge clk);
        check("rst_ack",         32'(ack),         32'd0);
        check("rst_tx_start",    32'(tx_start),    32'd0);
        check("rst_tx_din",      32'(tx_din),      32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_id",    32'(grant_id),    32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_rr_ptr",      32'(dut.r_rr_ptr), 32'd3);
        reset = 1'b0;
        clear_logs();

        // ---------- single requester, 3-byte packet ----------
        tx_model_en = 1'b1;
        @(negedge clk);
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b1);
        wait_drain("s1_drain", 400);
        check("s1_nbytes", 32'(tx_log.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("s1_din%0d", k), 32'(tx_log[k]),  32'h41 + 32'(k));
            check($sformatf("s1_ack%0d", k), 32'(ack_log[k]), 32'h2);
            check($sformatf("s1_own%0d", k), 32'(own_log[k]), 32'd1);
        end
        check("s1_ngrants",   32'(grant_log.size()), 32'd1);
        check("s1_b2b_lat",   32'(start_cyc[1] - tick_cyc[0]), 32'd2);
        check("s1_busy_end",  32'(busy), 32'd0);
        check("s1_rr_ptr",    32'(dut.r_rr_ptr), 32'd1);

        // ---------- all four requesting, 1-byte packets ----------
        do_reset();
        for (int r = 0; r < N_REQ; r++) begin
            push(r, 8'(r*16),     1'b1);
            push(r, 8'(r*16 + 1), 1'b1);
        end
        wait_drain("s2_drain", 600);
        check("s2_ngrants", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("s2_grant%0d", k), 32'(grant_log[k]), 32'(k % 4));
            check($sformatf("s2_din%0d", k),   32'(tx_log[k]),    32'((k % 4) * 16 + k / 4));
            check($sformatf("s2_ack%0d", k),   32'(ack_log[k]),   32'(1 << (k % 4)));
        end

        // ---------- burst limit ----------
        do_reset();
        for (int k = 0; k < 12; k++) push(2, 8'hA0 + 8'(k), 1'b0);
        push(3, 8'hC0, 1'b1);
        wait_drain("s3_drain", 800);
        check("s3_nbytes", 32'(tx_log.size()), 32'd13);
        for (int k = 0; k < 13; k++) begin
            logic [7:0] e;
            e = (k < 8) ? 8'hA0 + 8'(k) : (k == 8) ? 8'hC0 : 8'hA0 + 8'(k - 1);
            check($sformatf("s3_din%0d", k), 32'(tx_log[k]), 32'(e));
        end
        check("s3_ack8",    32'(ack_log[8]), 32'h8);
        check("s3_ngrants", 32'(grant_log.size()), 32'd3);
        check("s3_grant0",  32'(grant_log[0]), 32'd2);
        check("s3_grant1",  32'(grant_log[1]), 32'd3);
        check("s3_grant2",  32'(grant_log[2]), 32'd2);

        // ---------- requester drops req in LOAD ----------
        tx_model_en = 1'b0;
        do_reset();
        man_req[0] = 1'b1;
        @(negedge clk);
        check("s4_gv",   32'(grant_valid), 32'd1);
        check("s4_gid",  32'(grant_id),    32'd0);
        check("s4_busy", 32'(busy),        32'd1);
        man_req[0] = 1'b0;
        @(negedge clk);
        check("s4_tx_start", 32'(tx_start),    32'd0);
        check("s4_ack",      32'(ack),         32'd0);
        check("s4_gv_off",   32'(grant_valid), 32'd0);
        check("s4_busy_off", 32'(busy),        32'd0);
        check("s4_rr_ptr",   32'(dut.r_rr_ptr), 32'd0);
        repeat (2) @(negedge clk);
        check("s4_nbytes",   32'(tx_log.size()), 32'd0);

        // ---------- spurious ticks in IDLE and LOAD ----------
        do_reset();
        man_tick = 1'b1;
        @(negedge clk);
        man_tick = 1'b0;
        check("s5_idle_busy",  32'(busy),     32'd0);
        check("s5_idle_start", 32'(tx_start), 32'd0);
        man_req[1]  = 1'b1;
        man_last[1] = 1'b1;
        man_data[15:8] = 8'h5A;
        @(negedge clk);
        check("s5_gid",      32'(grant_id), 32'd1);
        check("s5_load_st",  32'(tx_start), 32'd0);
        man_tick = 1'b1;
        @(negedge clk);
        check("s5_start",    32'(tx_start), 32'd1);
        check("s5_din",      32'(tx_din),   32'h5A);
        check("s5_ack",      32'(ack),      32'h2);
        man_tick = 1'b0;
        man_req  = '0;
        man_last = '0;
        man_data = '0;
        @(negedge clk);
        check("s5_wait_busy",  32'(busy),     32'd1);
        check("s5_wait_start", 32'(tx_start), 32'd0);
        man_tick = 1'b1;
        @(negedge clk);
        man_tick = 1'b0;
        check("s5_rel_busy", 32'(busy),        32'd0);
        check("s5_rel_gv",   32'(grant_valid), 32'd0);
        check("s5_nbytes",   32'(tx_log.size()), 32'd1);

        // ---------- async reset mid-burst ----------
        tx_model_en = 1'b1;
        do_reset();
        push(0, 8'h01, 1'b1);
        wait_drain("s6_pre_drain", 200);
        clear_logs();
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h23, 1'b0);
        wait_starts("s6_two_bytes", 2, 200);
        @(negedge clk);
        check("s6_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("s6_async_gv",   32'(grant_valid), 32'd0);
        check("s6_async_busy", 32'(busy),        32'd0);
        check("s6_async_din",  32'(tx_din),      32'd0);
        check("s6_async_gid",  32'(grant_id),    32'd0);
        for (int i = 0; i < N_REQ; i++) qhead[i] = qtail[i];
        repeat (2) @(negedge clk);
        clear_logs();
        push(0, 8'h0A, 1'b1);
        push(1, 8'h1A, 1'b1);
        reset = 1'b0;
        wait_drain("s6_post_drain", 300);
        check("s6_grant0", 32'(grant_log[0]), 32'd0);
        check("s6_grant1", 32'(grant_log[1]), 32'd1);
        check("s6_din0",   32'(tx_log[0]),    32'h0A);

        check("pulse_spacing", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
